// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for the multicycle MIPS datapath. A Moore state register
// sequences fetch, decode, execute, memory and write-back; every datapath
// enable and mux select is decoded combinationally from the current state.
// The only exceptions are:
//   - FETCH IRWrite/PCWrite, which are gated by mem_ready.
//   - MEM_WR instr_done, which is gated by mem_ready.
//   - EXEC_I ALUOp and BRANCH BranchEQ/BranchNE, which are decoded from OP.
//
// Optional feature macro: MULTICYCLE_JAL_EN
//   - Defined: OP 0x03 runs through the JAL state.
//   - Undefined: OP 0x03 is illegal.
//
// Parameters:
//   ALUOP_WIDTH   width of ALUOp (>= 3); codes are zero-extended
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset (forces IDLE)
//   OP            opcode from the instruction register
//   mem_ready     memory completes the current access this cycle
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
//   BranchEQ, BranchNE
//                 single-bit datapath controls
//   ALUSrcB       00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   PCSource      00 ALU result, 01 ALUOut, 10 jump target
//   RegDst        00 rt, 01 rd, 10 $31
//   MemtoReg      00 ALUOut, 01 MDR, 10 PC
//   ALUOp         ALU operation code
//   state         current state (debug)
//   instr_done    pulse in the last cycle of each instruction
//   illegal_op    pulse in DECODE when OP is unsupported
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALUOP_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   ALUSrcA,
    output logic                   RegWrite,
    output logic                   BranchEQ,
    output logic                   BranchNE,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemtoReg,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic [3:0]             state,
    output logic                   instr_done,
    output logic                   illegal_op
);

    generate
        if (ALUOP_WIDTH < 3) begin : g_width_check
            $error("multicycle_control: ALUOP_WIDTH must be >= 3");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_EXEC_R  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_EXEC_I  = 4'd9,
        S_IMM_WB  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
`ifdef MULTICYCLE_JAL_EN
        ,
        S_JAL     = 4'd13
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [2:0] ALU_RTYPE = 3'b111;
    localparam logic [2:0] ALU_ADDI  = 3'b110;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;

    state_t     cur;
    state_t     nxt;
    logic [2:0] alu_code;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    assign state = cur;

    // Next-state logic
    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_IDLE:    nxt = S_FETCH;
            S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OP)
                    OP_RTYPE:                          nxt = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  nxt = S_EXEC_I;
                    OP_LW, OP_SW:                      nxt = S_MEM_ADR;
                    OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
                    OP_J:                              nxt = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL:                            nxt = S_JAL;
`endif
                    default:                           nxt = S_FETCH;
                endcase
            end
            S_MEM_ADR: nxt = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:  nxt = S_FETCH;
            S_MEM_WR:  nxt = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:  nxt = S_ALU_WB;
            S_ALU_WB:  nxt = S_FETCH;
            S_EXEC_I:  nxt = S_IMM_WB;
            S_IMM_WB:  nxt = S_FETCH;
            S_BRANCH:  nxt = S_FETCH;
            S_JUMP:    nxt = S_FETCH;
`ifdef MULTICYCLE_JAL_EN
            S_JAL:     nxt = S_FETCH;
`endif
            default:   nxt = S_IDLE;
        endcase
    end

    // Output decode: everything defaults to 0, each state raises only its own
    // controls. IDLE (and therefore reset) falls through to all-zero.
    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        BranchEQ   = 1'b0;
        BranchNE   = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        alu_code   = 3'b000;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = 2'b01;
                alu_code = ALU_ADD;
                // Latch IR and advance PC only on the cycle memory delivers.
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB  = 2'b11;
                alu_code = ALU_ADD;
                case (OP)
                    OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
                    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: begin
                        illegal_op = 1'b0;
                    end
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL: begin
                        illegal_op = 1'b0;
                    end
`endif
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                alu_code = ALU_ADD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA  = 1'b1;
                alu_code = ALU_RTYPE;
            end
            S_ALU_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (OP)
                    OP_ADDI: alu_code = ALU_ADDI;
                    OP_ANDI: alu_code = ALU_AND;
                    OP_ORI:  alu_code = ALU_OR;
                    OP_LUI:  alu_code = ALU_LUI;
                    default: alu_code = 3'b000;
                endcase
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_code   = ALU_SUB;
                PCSource   = 2'b01;
                BranchEQ   = (OP == OP_BEQ);
                BranchNE   = (OP == OP_BNE);
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_JAL_EN
            S_JAL: begin
                // PC already holds PC+4 from FETCH; it is written to $31
                // in the same cycle the PC is loaded with the jump target.
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                instr_done = 1'b1;
            end
`endif
            default: begin
                instr_done = 1'b0;
            end
        endcase
    end

    assign ALUOp = ALUOP_WIDTH'(alu_code);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic       BranchEQ, BranchNE;
    logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .OP         (OP),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .BranchEQ   (BranchEQ),
        .BranchNE   (BranchNE),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUOp      (ALUOp),
        .state      (state),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    // flags: {PCWrite,IorD,MemRead,MemWrite,IRWrite,ALUSrcA,RegWrite,BranchEQ,BranchNE}
    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [8:0] flags;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] m2r;
        logic [2:0] aluop;
        logic       done;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic rst_n, logic [5:0] op, logic rdy,
                                logic [3:0] st, logic [8:0] flags, logic [1:0] srcb,
                                logic [1:0] pcsrc, logic [1:0] regdst, logic [1:0] m2r,
                                logic [2:0] aluop, logic done, logic ill);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.op = op; v.rdy = rdy; v.st = st;
        v.flags = flags; v.srcb = srcb; v.pcsrc = pcsrc; v.regdst = regdst;
        v.m2r = m2r; v.aluop = aluop; v.done = done; v.ill = ill;
        return v;
    endfunction

    // Common rows
    function automatic vec_t fetch_ok(string n, logic [5:0] op);
        return mk(n, 1, op, 1, 4'd1, 9'b101010000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0);
    endfunction
    function automatic vec_t decode_ok(string n, logic [5:0] op, logic rdy);
        return mk(n, 1, op, rdy, 4'd2, 9'b000000000, 2'b11, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0);
    endfunction
    function automatic vec_t zero_row(string n, logic rst_n, logic [5:0] op, logic rdy);
        return mk(n, rst_n, op, rdy, 4'd0, 9'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    endfunction

    task automatic apply_and_check(input vec_t v);
        logic [25:0] act, exp;
        @(negedge clk);
        reset     = v.rst_n;
        OP        = v.op;
        mem_ready = v.rdy;
        #1;
        act = {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
               BranchEQ, BranchNE, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp,
               instr_done, illegal_op};
        exp = {v.st, v.flags, v.srcb, v.pcsrc, v.regdst, v.m2r, v.aluop, v.done, v.ill};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %07h expected %07h (state got %0d expected %0d)",
                     v.name, act, exp, state, v.st);
        end
        checks++;
        if (MemRead === 1'b1 && MemWrite === 1'b1) begin
            errors++;
            $display("FAIL %s_rd_wr_excl: MemRead=%b MemWrite=%b, required not both 1",
                     v.name, MemRead, MemWrite);
        end
    endtask

    initial begin
        reset     = 1'b0;
        OP        = 6'h00;
        mem_ready = 1'b1;

        // Reset held low for 3 cycles, then release: IDLE for one clock.
        vecs.push_back(zero_row("rst0", 0, 6'h00, 1));
        vecs.push_back(zero_row("rst1", 0, 6'h00, 1));
        vecs.push_back(zero_row("rst2", 0, 6'h00, 1));
        vecs.push_back(zero_row("idle", 1, 6'h00, 1));

        // R-type: 1,2,7,8
        vecs.push_back(fetch_ok("r_fetch", 6'h00));
        vecs.push_back(decode_ok("r_decode", 6'h00, 1));
        vecs.push_back(mk("r_exec", 1, 6'h00, 1, 4'd7, 9'b000001000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, 0, 0));
        vecs.push_back(mk("r_wb", 1, 6'h00, 1, 4'd8, 9'b000000100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1, 0));

        // LW with 2 FETCH waits and 3 MEM_RD waits: 10 cycles
        vecs.push_back(mk("lw_fwait0", 1, 6'h23, 0, 4'd1, 9'b001000000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0));
        vecs.push_back(mk("lw_fwait1", 1, 6'h23, 0, 4'd1, 9'b001000000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0));
        vecs.push_back(fetch_ok("lw_fetch", 6'h23));
        vecs.push_back(decode_ok("lw_decode", 6'h23, 1));
        vecs.push_back(mk("lw_adr", 1, 6'h23, 1, 4'd3, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0));
        vecs.push_back(mk("lw_rwait0", 1, 6'h23, 0, 4'd4, 9'b011000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        vecs.push_back(mk("lw_rwait1", 1, 6'h23, 0, 4'd4, 9'b011000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        vecs.push_back(mk("lw_rwait2", 1, 6'h23, 0, 4'd4, 9'b011000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        vecs.push_back(mk("lw_rd", 1, 6'h23, 1, 4'd4, 9'b011000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        vecs.push_back(mk("lw_wb", 1, 6'h23, 1, 4'd5, 9'b000000100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1, 0));

        // BNE: 3 cycles
        vecs.push_back(fetch_ok("bne_fetch", 6'h05));
        vecs.push_back(decode_ok("bne_decode", 6'h05, 1));
        vecs.push_back(mk("bne_br", 1, 6'h05, 1, 4'd11, 9'b000001001, 2'b00, 2'b01, 2'b00, 2'b00, 3'b100, 1, 0));

        // SW with one MEM_WR wait
        vecs.push_back(fetch_ok("sw_fetch", 6'h2b));
        vecs.push_back(decode_ok("sw_decode", 6'h2b, 1));
        vecs.push_back(mk("sw_adr", 1, 6'h2b, 1, 4'd3, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0));
        vecs.push_back(mk("sw_wwait", 1, 6'h2b, 0, 4'd6, 9'b010100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        vecs.push_back(mk("sw_wr", 1, 6'h2b, 1, 4'd6, 9'b010100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        // BEQ
        vecs.push_back(fetch_ok("beq_fetch", 6'h04));
        vecs.push_back(decode_ok("beq_decode", 6'h04, 1));
        vecs.push_back(mk("beq_br", 1, 6'h04, 1, 4'd11, 9'b000001010, 2'b00, 2'b01, 2'b00, 2'b00, 3'b100, 1, 0));

        // ORI with mem_ready low outside FETCH/MEM states (must be ignored)
        vecs.push_back(fetch_ok("ori_fetch", 6'h0d));
        vecs.push_back(decode_ok("ori_decode", 6'h0d, 0));
        vecs.push_back(mk("ori_exec", 1, 6'h0d, 0, 4'd9, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b101, 0, 0));
        vecs.push_back(mk("ori_wb", 1, 6'h0d, 0, 4'd10, 9'b000000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        // ADDI / ANDI / LUI ALUOp in EXEC_I
        vecs.push_back(fetch_ok("addi_fetch", 6'h08));
        vecs.push_back(decode_ok("addi_decode", 6'h08, 1));
        vecs.push_back(mk("addi_exec", 1, 6'h08, 1, 4'd9, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b110, 0, 0));
        vecs.push_back(mk("addi_wb", 1, 6'h08, 1, 4'd10, 9'b000000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        vecs.push_back(fetch_ok("andi_fetch", 6'h0c));
        vecs.push_back(decode_ok("andi_decode", 6'h0c, 1));
        vecs.push_back(mk("andi_exec", 1, 6'h0c, 1, 4'd9, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b011, 0, 0));
        vecs.push_back(mk("andi_wb", 1, 6'h0c, 1, 4'd10, 9'b000000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        vecs.push_back(fetch_ok("lui_fetch", 6'h0f));
        vecs.push_back(decode_ok("lui_decode", 6'h0f, 1));
        vecs.push_back(mk("lui_exec", 1, 6'h0f, 1, 4'd9, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
        vecs.push_back(mk("lui_wb", 1, 6'h0f, 1, 4'd10, 9'b000000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        // J
        vecs.push_back(fetch_ok("j_fetch", 6'h02));
        vecs.push_back(decode_ok("j_decode", 6'h02, 1));
        vecs.push_back(mk("j_jump", 1, 6'h02, 1, 4'd12, 9'b100000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 1, 0));

        // Illegal OP 0x3f: 2 cycles, back to FETCH
        vecs.push_back(fetch_ok("ill_fetch", 6'h3f));
        vecs.push_back(mk("ill_decode", 1, 6'h3f, 1, 4'd2, 9'b0, 2'b11, 2'b00, 2'b00, 2'b00, 3'b010, 1, 1));

        // OP 0x03 (JAL or illegal depending on build)
        vecs.push_back(fetch_ok("jal_fetch", 6'h03));
`ifdef MULTICYCLE_JAL_EN
        vecs.push_back(decode_ok("jal_decode", 6'h03, 1));
        vecs.push_back(mk("jal_jal", 1, 6'h03, 1, 4'd13, 9'b100000100, 2'b00, 2'b10, 2'b10, 2'b10, 3'b000, 1, 0));
`else
        vecs.push_back(mk("jal_illegal", 1, 6'h03, 1, 4'd2, 9'b0, 2'b11, 2'b00, 2'b00, 2'b00, 3'b010, 1, 1));
`endif

        // Reset dropped while waiting in MEM_RD, then restart IDLE -> FETCH
        vecs.push_back(fetch_ok("rr_fetch", 6'h23));
        vecs.push_back(decode_ok("rr_decode", 6'h23, 1));
        vecs.push_back(mk("rr_adr", 1, 6'h23, 1, 4'd3, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0));
        vecs.push_back(mk("rr_rwait", 1, 6'h23, 0, 4'd4, 9'b011000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        vecs.push_back(zero_row("rr_reset", 0, 6'h23, 0));
        vecs.push_back(zero_row("rr_idle", 1, 6'h23, 1));
        vecs.push_back(fetch_ok("rr_refetch", 6'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_and_check(vecs[i]);
        end

        // Hand-written: asynchronous reset assertion mid-cycle in MEM_RD wait,
        // checked before any clock edge arrives.
        apply_and_check(decode_ok("ar_decode", 6'h23, 1));
        apply_and_check(mk("ar_adr", 1, 6'h23, 1, 4'd3, 9'b000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0));
        apply_and_check(mk("ar_rwait", 1, 6'h23, 0, 4'd4, 9'b011000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || MemRead !== 1'b0 || IorD !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d MemRead=%b IorD=%b, required 0/0/0",
                     state, MemRead, IorD);
        end
        apply_and_check(zero_row("ar_idle", 1, 6'h00, 1));
        apply_and_check(fetch_ok("ar_fetch", 6'h00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control FSM for the multicycle MIPS datapath: the parametrised successor to the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and write-back over several clocks and drives every datapath enable and mux select from a Moore state register. It supports a variable-latency memory via a ready handshake, covers branches, jumps and stores, and keeps the existing ALUOp encoding.

## Interface
- ALUOP_WIDTH, 3: width of ALUOp. Must be ≥3. Codes are zero-extended.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- OP  in  6  opcode from the instruction register; stable from DECODE until FETCH
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, BranchEQ, BranchNE  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
- ALUOp  out  ALUOP_WIDTH  111 R-type (funct), 110 add-imm, 011 and, 101 or, 001 lui, 010 add, 100 sub
- state  out  4  current state (debug)
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE when OP is unsupported

## Operation
- States and encoding: IDLE 0, FETCH 1, DECODE 2, MEM_ADR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, ALU_WB 8, EXEC_I 9, IMM_WB 10, BRANCH 11, JUMP 12, JAL 13.
- Outputs not listed for a state are 0.
- **IDLE:** all outputs 0. Always goes to FETCH.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00.
  - IRWrite and PCWrite are each equal to mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=010. Next state by OP:
  - 0x00 → EXEC_R
  - 0x08, 0x0c, 0x0d, 0x0f → EXEC_I
  - 0x23, 0x2b → MEM_ADR
  - 0x04, 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL (only when the macro is defined)
  - any other OP → FETCH, with illegal_op=1 and instr_done=1
- **MEM_ADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=010. Goes to MEM_RD when OP=0x23, otherwise MEM_WR.
- **MEM_RD:** MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEM_WB.
- **MEM_WB:** RegWrite=1, RegDst=00, MemtoReg=01. Goes to FETCH.
- **MEM_WR:** MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
- **EXEC_R:** ALUSrcA=1, ALUSrcB=00, ALUOp=111. Goes to ALU_WB.
- **ALU_WB:** RegWrite=1, RegDst=01, MemtoReg=00. Goes to FETCH.
- **EXEC_I:** ALUSrcA=1, ALUSrcB=10. ALUOp by OP: 0x08→110, 0x0c→011, 0x0d→101, 0x0f→001. Goes to IMM_WB.
- **IMM_WB:** RegWrite=1, RegDst=00, MemtoReg=00. Goes to FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01. BranchEQ=(OP==0x04), BranchNE=(OP==0x05). Goes to FETCH.
- **JUMP:** PCWrite=1, PCSource=10. Goes to FETCH.
- instr_done=1 in the final cycle before returning to FETCH. In MEM_RD, MEM_WR and FETCH it is never asserted while waiting.

## Timing
- Outputs are Moore, decoded combinationally from the state register. The exceptions are FETCH IRWrite/PCWrite, which are gated by mem_ready.
- ALUOp in EXEC_I and BranchEQ/BranchNE in BRANCH are decoded from OP.
- Asserting reset (low) forces IDLE asynchronously. All outputs are 0 and state=0 while reset is low, including when reset arrives mid-instruction or mid-wait.
- After reset deasserts: IDLE for one clock, then FETCH.
- Cycles per instruction with mem_ready tied to 1:
  - R-type / I-ALU / SW: 4
  - LW: 5
  - BEQ / BNE / J / JAL: 3
  - illegal OP: 2
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready is ignored in all other states.
- MemRead and MemWrite are never both 1 in any state.

## Configuration
- MULTICYCLE_JAL_EN defined:
  - OP 0x03 in DECODE goes to JAL.
  - JAL drives PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10, then goes to FETCH.
  - The write to $31 captures the PC+4 already in the PC register.
- MULTICYCLE_JAL_EN undefined:
  - The JAL state is absent.
  - OP 0x03 is treated as illegal: illegal_op pulse, return to FETCH, no register or PC write.

## Test plan
- Reset low for 3 cycles, then release with mem_ready=1 → all outputs 0 and state=0 during reset; state 0→1 on the first clock after release; IRWrite=PCWrite=1 in FETCH.
- OP=0x00, mem_ready=1 → state sequence 1,2,7,8,1; ALUOp=111 in EXEC_R; RegWrite=1 and RegDst=01 in ALU_WB; instr_done pulses only in ALU_WB.
- OP=0x23, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD → IRWrite=0 during the FETCH waits; MemRead stays 1 throughout; total 10 cycles; MemtoReg=01 in MEM_WB.
- OP=0x05 then OP=0x2b → BNE: BranchNE=1, BranchEQ=0, ALUOp=100, 3 cycles. SW: MemWrite=1, IorD=1 in MEM_WR; RegWrite never 1.
- OP=0x3f → illegal_op=1 in DECODE; next state FETCH; no RegWrite or MemWrite. Repeat with OP=0x03 in both macro builds: with the macro, JAL asserts RegDst=10 and MemtoReg=10; without it, illegal_op=1.
- Drop reset while in MEM_RD waiting → outputs 0 immediately (before the next clock edge); after release the sequence restarts at IDLE→FETCH.
